// File: rtl/ov7670_pixel_capture.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_pixel_capture
// Purpose  : Capture front-end for OV7670-class parallel cameras. Generates
//            MCLK, oversamples PCLK/VSYNC/HREF/D[7:0] in the system clock
//            domain and assembles RAW8 or 2-byte pixels with X/Y coordinates,
//            frame start/done pulses, geometry error flags and frame count.
// Ports    : i_Clk, i_Rst_n (async, active low), i_Enable (capture level)
//            i_PCLK/i_VSYNC/i_HREF/i_Data : camera pins (asynchronous)
//            o_MCLK                       : camera master clock
//            o_Pixel/o_Pixel_Valid/o_X/o_Y: pixel stream
//            o_Frame_Start/o_Frame_Done   : frame pulses
//            o_Line_Err/o_Frame_Err       : sticky geometry errors
//            o_Frame_Count, o_Busy        : status
// Revision : 1.0 - initial release
// ============================================================================
module ov7670_pixel_capture #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int MODE      = 1,
  parameter int BYTE_SWAP = 0,
  parameter int MCLK_DIV  = 2,
  parameter int XW        = 10,
  parameter int YW        = 9
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  input  logic          i_Enable,
  input  logic          i_PCLK,
  input  logic          i_VSYNC,
  input  logic          i_HREF,
  input  logic [7:0]    i_Data,
  output logic          o_MCLK,
  output logic [15:0]   o_Pixel,
  output logic          o_Pixel_Valid,
  output logic [XW-1:0] o_X,
  output logic [YW-1:0] o_Y,
  output logic          o_Frame_Start,
  output logic          o_Frame_Done,
  output logic          o_Line_Err,
  output logic          o_Frame_Err,
  output logic [15:0]   o_Frame_Count,
  output logic          o_Busy
);

  localparam int            CW       = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(MCLK_DIV - 1);
  localparam logic [XW-1:0] H_MAX    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_MAX    = YW'(V_ACTIVE);
  localparam logic          IS_RAW8  = (MODE == 0);
  localparam logic          SWAPPED  = (BYTE_SWAP != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // MCLK divider: free-running, independent of capture enable
  // --------------------------------------------------------------------------
  logic [CW-1:0] mclk_cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      mclk_cnt <= '0;
      o_MCLK   <= 1'b0;
    end else if (mclk_cnt == DIV_LAST) begin
      mclk_cnt <= '0;
      o_MCLK   <= ~o_MCLK;
    end else begin
      mclk_cnt <= mclk_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Two-flop synchronisers plus one history flop for edge detection.
  // HREF and Data are used from the same (second) stage as PCLK so that a
  // byte and its qualifier stay aligned with the sample event.
  // --------------------------------------------------------------------------
  logic [1:0] pclk_sync, vsync_sync, href_sync;
  logic [7:0] data_s0, data_s1;
  logic       pclk_prev, vsync_prev, href_prev;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      pclk_sync  <= '0;
      vsync_sync <= '0;
      href_sync  <= '0;
      data_s0    <= '0;
      data_s1    <= '0;
      pclk_prev  <= 1'b0;
      vsync_prev <= 1'b0;
      href_prev  <= 1'b0;
    end else begin
      pclk_sync  <= {pclk_sync[0], i_PCLK};
      vsync_sync <= {vsync_sync[0], i_VSYNC};
      href_sync  <= {href_sync[0], i_HREF};
      data_s0    <= i_Data;
      data_s1    <= data_s0;
      pclk_prev  <= pclk_sync[1];
      vsync_prev <= vsync_sync[1];
      href_prev  <= href_sync[1];
    end
  end

  // --------------------------------------------------------------------------
  // Capture datapath decode
  // --------------------------------------------------------------------------
  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          byte_phase;
  logic [7:0]    first_byte;

  logic          href_now, href_fall, vsync_rise, vsync_fall;
  logic          sample, pix_done, in_bounds;
  logic [15:0]   pix_word;
  logic [XW-1:0] x_inc;
  logic [YW-1:0] y_line;

  always_comb begin
    href_now   = href_sync[1];
    href_fall  = href_prev & ~href_sync[1];
    vsync_rise = vsync_sync[1] & ~vsync_prev;
    vsync_fall = vsync_prev & ~vsync_sync[1];
    sample     = pclk_sync[1] & ~pclk_prev & href_sync[1];
    pix_done   = sample & (IS_RAW8 | byte_phase);
    in_bounds  = (x < H_MAX) && (y < V_MAX);
    x_inc      = (x == H_MAX) ? x : x + 1'b1;
    // Y as it stands after a coincident line end, so frame-end checks see it
    y_line     = (href_fall && (y != V_MAX)) ? y + 1'b1 : y;
    if (IS_RAW8)
      pix_word = {8'h00, data_s1};
    else if (SWAPPED)
      pix_word = {data_s1, first_byte};
    else
      pix_word = {first_byte, data_s1};
  end

  // --------------------------------------------------------------------------
  // Capture FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      byte_phase    <= 1'b0;
      first_byte    <= '0;
      o_Pixel       <= '0;
      o_Pixel_Valid <= 1'b0;
      o_X           <= '0;
      o_Y           <= '0;
      o_Frame_Start <= 1'b0;
      o_Frame_Done  <= 1'b0;
      o_Line_Err    <= 1'b0;
      o_Frame_Err   <= 1'b0;
      o_Frame_Count <= '0;
    end else begin
      o_Pixel_Valid <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Frame_Done  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Enable)
            state <= SYNC;
        end
        SYNC: begin
          if (!i_Enable) begin
            state <= IDLE;
          end else if (vsync_fall) begin
            state      <= ACTIVE;
            x          <= '0;
            y          <= '0;
            byte_phase <= 1'b0;
          end
        end
        ACTIVE: begin
          if (sample && !IS_RAW8) begin
            if (!byte_phase)
              first_byte <= data_s1;
            byte_phase <= ~byte_phase;
          end
          if (pix_done) begin
            x <= x_inc;
            if (in_bounds) begin
              o_Pixel_Valid <= 1'b1;
              o_Pixel       <= pix_word;
              o_X           <= x;
              o_Y           <= y;
              if (x == '0 && y == '0) begin
                o_Frame_Start <= 1'b1;
                o_Line_Err    <= 1'b0;
                o_Frame_Err   <= 1'b0;
              end
            end else begin
              if (x >= H_MAX) o_Line_Err  <= 1'b1;
              if (y >= V_MAX) o_Frame_Err <= 1'b1;
            end
          end
          if (href_fall) begin
            if (x != H_MAX || byte_phase)
              o_Line_Err <= 1'b1;
            x          <= '0;
            byte_phase <= 1'b0;
            y          <= y_line;
          end
          if (vsync_rise) begin
            if (y_line != V_MAX) o_Frame_Err <= 1'b1;
            if (href_now)        o_Line_Err  <= 1'b1;
            o_Frame_Done  <= 1'b1;
            o_Frame_Count <= o_Frame_Count + 16'd1;
            state         <= i_Enable ? SYNC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_Busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ov7670_pixel_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov7670_pixel_capture
// Purpose  : Directed testbench for ov7670_pixel_capture. Three instances
//            share one camera bus: d0 RAW8 4x3 (MCLK_DIV 2), d1 2-byte 2x3
//            no swap (MCLK_DIV 1), d2 2-byte 2x3 swapped (MCLK_DIV 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ov7670_pixel_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] data;

  always #5 clk = ~clk;

  logic        mclk0, v0, fs0, fd0, le0, fe0, busy0;
  logic [15:0] pix0, cnt0;
  logic [7:0]  x0, y0;
  logic        mclk1, v1, fs1, fd1, le1, fe1, busy1;
  logic [15:0] pix1, cnt1;
  logic [7:0]  x1, y1;
  logic        mclk2, v2, fs2, fd2, le2, fe2, busy2;
  logic [15:0] pix2, cnt2;
  logic [7:0]  x2, y2;

  ov7670_pixel_capture #(.H_ACTIVE(4), .V_ACTIVE(3), .MODE(0), .BYTE_SWAP(0),
                         .MCLK_DIV(2), .XW(8), .YW(8)) d0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(enable), .i_PCLK(pclk),
    .i_VSYNC(vsync), .i_HREF(href), .i_Data(data), .o_MCLK(mclk0),
    .o_Pixel(pix0), .o_Pixel_Valid(v0), .o_X(x0), .o_Y(y0),
    .o_Frame_Start(fs0), .o_Frame_Done(fd0), .o_Line_Err(le0),
    .o_Frame_Err(fe0), .o_Frame_Count(cnt0), .o_Busy(busy0));

  ov7670_pixel_capture #(.H_ACTIVE(2), .V_ACTIVE(3), .MODE(1), .BYTE_SWAP(0),
                         .MCLK_DIV(1), .XW(8), .YW(8)) d1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(enable), .i_PCLK(pclk),
    .i_VSYNC(vsync), .i_HREF(href), .i_Data(data), .o_MCLK(mclk1),
    .o_Pixel(pix1), .o_Pixel_Valid(v1), .o_X(x1), .o_Y(y1),
    .o_Frame_Start(fs1), .o_Frame_Done(fd1), .o_Line_Err(le1),
    .o_Frame_Err(fe1), .o_Frame_Count(cnt1), .o_Busy(busy1));

  ov7670_pixel_capture #(.H_ACTIVE(2), .V_ACTIVE(3), .MODE(1), .BYTE_SWAP(1),
                         .MCLK_DIV(2), .XW(8), .YW(8)) d2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(enable), .i_PCLK(pclk),
    .i_VSYNC(vsync), .i_HREF(href), .i_Data(data), .o_MCLK(mclk2),
    .o_Pixel(pix2), .o_Pixel_Valid(v2), .o_X(x2), .o_Y(y2),
    .o_Frame_Start(fs2), .o_Frame_Done(fd2), .o_Line_Err(le2),
    .o_Frame_Err(fe2), .o_Frame_Count(cnt2), .o_Busy(busy2));

  // Output capture, sampled on the falling edge
  logic [31:0] q0[$], q1[$], q2[$];
  int starts0 = 0, dones0 = 0;

  always @(negedge clk) begin
    if (v0) q0.push_back({y0, x0, pix0});
    if (v1) q1.push_back({y1, x1, pix1});
    if (v2) q2.push_back({y2, x2, pix2});
    if (fs0) starts0++;
    if (fd0) dones0++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int yy, input int xx, input int pp);
    return {yy[7:0], xx[7:0], pp[15:0]};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    data = b;
    repeat (3) @(negedge clk);
    pclk = 1'b1;
    repeat (3) @(negedge clk);
    pclk = 1'b0;
  endtask

  task automatic send_line(input int n, input int base);
    href = 1'b1;
    for (int i = 0; i < n; i++) send_byte(8'(base + i));
    href = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_line4(input logic [31:0] w);
    href = 1'b1;
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    href = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    repeat (8) @(negedge clk);
    vsync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  function automatic logic mclk_of(input int which);
    return (which == 0) ? mclk0 : mclk1;
  endfunction

  // Cycles between two rising edges of the selected MCLK, -1 on timeout
  task automatic measure_mclk(input int which, output int period);
    logic prev, cur;
    int   n;
    bit   found;
    prev = mclk_of(which);
    found = 0;
    n = 0;
    while (!found && n < 20) begin
      @(negedge clk); n++;
      cur = mclk_of(which);
      if (!prev && cur) found = 1;
      prev = cur;
    end
    period = -1;
    if (found) begin
      found = 0;
      n = 0;
      while (!found && n < 20) begin
        @(negedge clk); n++;
        cur = mclk_of(which);
        if (!prev && cur) found = 1;
        prev = cur;
      end
      if (found) period = n;
    end
  endtask

  int s0, s1, s2, st0, dn0, per;

  initial begin
    rst_n = 1'b0; enable = 1'b0; pclk = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst_pixel", pix0, 0);
    check("rst_valid", v0, 0);
    check("rst_count", cnt0, 0);
    check("rst_busy", busy0, 0);
    check("rst_mclk", mclk0, 0);
    check("rst_errs", {le0, fe0}, 0);
    check("rst_xy", {x0, y0}, 0);

    rst_n = 1'b1;
    measure_mclk(0, per);
    check("mclk_period_div2", per, 4);
    measure_mclk(1, per);
    check("mclk_period_div1", per, 2);

    // Enable raised mid-frame: this frame must not be captured
    vsync_pulse();
    send_line(4, 'h50);
    enable = 1'b1;
    send_line(4, 'h54);
    send_line(4, 'h58);
    vsync_pulse();
    check("partial_valids", q0.size(), 0);
    check("partial_dones", dones0, 0);
    check("busy_sync", busy0, 1);

    // Clean frame 0x00..0x0B
    s0 = q0.size(); s1 = q1.size(); s2 = q2.size(); st0 = starts0; dn0 = dones0;
    send_line(4, 'h00);
    send_line(4, 'h04);
    send_line(4, 'h08);
    vsync_pulse();
    check("clean_n0", q0.size() - s0, 12);
    for (int i = 0; i < 12; i++)
      if (s0 + i < q0.size()) check("clean_d0_pix", q0[s0 + i], ent(i / 4, i % 4, i));
    check("clean_n1", q1.size() - s1, 6);
    check("clean_n2", q2.size() - s2, 6);
    for (int i = 0; i < 6; i++) begin
      int b;
      b = 2 * i;
      if (s1 + i < q1.size()) check("clean_d1_pix", q1[s1 + i], ent(i / 2, i % 2, (b << 8) | (b + 1)));
      if (s2 + i < q2.size()) check("clean_d2_pix", q2[s2 + i], ent(i / 2, i % 2, ((b + 1) << 8) | b));
    end
    check("clean_starts", starts0 - st0, 1);
    check("clean_dones", dones0 - dn0, 1);
    check("clean_count", cnt0, 1);
    check("clean_errs0", {le0, fe0}, 0);
    check("clean_errs12", {le1, fe1, le2, fe2}, 0);

    // Two-byte assembly, both byte orders
    s1 = q1.size(); s2 = q2.size();
    send_line4(32'hA1B2C3D4);
    send_line(4, 'h10);
    send_line(4, 'h14);
    vsync_pulse();
    check("m1_n1", q1.size() - s1, 6);
    if (q1.size() >= s1 + 2) begin
      check("m1_swap0_p0", q1[s1], ent(0, 0, 'hA1B2));
      check("m1_swap0_p1", q1[s1 + 1], ent(0, 1, 'hC3D4));
    end
    if (q2.size() >= s2 + 2) begin
      check("m1_swap1_p0", q2[s2], ent(0, 0, 'hB2A1));
      check("m1_swap1_p1", q2[s2 + 1], ent(0, 1, 'hD4C3));
    end
    check("m1_count1", cnt1, 2);

    // Over-long line: 5th byte dropped, line error sticks through Done
    s0 = q0.size();
    send_line(5, 'h30);
    check("long_valids", q0.size() - s0, 4);
    check("long_line_err", le0, 1);
    send_line(4, 'h40);
    send_line(4, 'h44);
    vsync_pulse();
    check("long_after_done_le", le0, 1);
    check("long_fe", fe0, 0);
    check("long_count", cnt0, 3);

    // Short frame: line error clears at Start, frame error at VSYNC rise
    dn0 = dones0;
    send_line(4, 'h60);
    check("start_clears_le", le0, 0);
    send_line(4, 'h64);
    vsync_pulse();
    check("short_fe", fe0, 1);
    check("short_dones", dones0 - dn0, 1);
    check("short_count", cnt0, 4);

    // Enable dropped mid-frame: frame completes, then idle
    s0 = q0.size();
    send_line(4, 'h70);
    enable = 1'b0;
    send_line(4, 'h74);
    send_line(4, 'h78);
    vsync_pulse();
    check("dis_valids", q0.size() - s0, 12);
    check("dis_count", cnt0, 5);
    check("dis_fe", fe0, 0);
    check("dis_busy", busy0, 0);

    // Asynchronous reset in the middle of a line
    enable = 1'b1;
    vsync_pulse();
    href = 1'b1;
    send_byte(8'h90);
    send_byte(8'h91);
    rst_n = 1'b0;
    #1;
    check("arst_count", cnt0, 0);
    check("arst_busy", busy0, 0);
    check("arst_pixel", pix0, 0);
    check("arst_x", x0, 0);
    check("arst_mclk1", mclk1, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = q0.size(); st0 = starts0;
    send_byte(8'h92);
    send_byte(8'h93);
    href = 1'b0;
    repeat (6) @(negedge clk);
    send_line(4, 'h94);
    check("arst_no_pix", q0.size() - s0, 0);
    vsync_pulse();
    s0 = q0.size();
    send_line(4, 'h20);
    check("arst_restart_n", q0.size() - s0, 4);
    if (q0.size() > s0) check("arst_restart_p0", q0[s0], ent(0, 0, 'h20));
    check("arst_restart_start", starts0 - st0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
